// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter.
// Holds the FSM state encoding, the parity_mode encodings and the legal
// configuration ranges for DATA_BITS / STOP_BITS.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP
  } tx_state_e;
`endif

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;  // decoded as none

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // One counter walks data bits (0..DATA_BITS-1) and then stop bits;
  // sized for the widest legal payload so it never wraps.
  localparam int BIT_CNT_W = $clog2(DATA_BITS_MAX);

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready byte handshake into the UART transmitter.
//   tx_valid : producer offers tx_data
//   tx_data  : payload, DATA_BITS wide, sent LSB first
//   tx_ready : transmitter idle; transfer when valid && ready at a clk edge
interface uart_tx_param_if #(parameter int DATA_BITS = 8);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter.
//   clk, rst : clock, synchronous active-high reset
//   restart  : clear the count (frame accepted)
//   en       : count while a frame is in flight
//   period   : cycles per bit, must already be >= 1
//   bit_end  : one-cycle strobe in the last cycle of each bit period
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Count stays within 0..period-1, so a DIV_W-bit counter cannot wrap.
  assign bit_end = en && (cnt_q == period - DIV_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (restart)   cnt_d = '0;
    else if (en)   cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS payload LSB first,
// optional parity bit, STOP_BITS stop bits. All outputs are registered.
//   clk, rst      : clock, synchronous active-high reset
//   clks_per_bit  : runtime bit period (0 treated as 1), latched on accept
//   parity_mode   : 00 none, 01 even, 10 odd, 11 none; latched on accept
//   tx_if         : valid/ready handshake carrying the payload
//   tx_serial     : serial line, idle high
//   tx_busy       : high outside IDLE
//   tx_done       : one-cycle pulse on the return to IDLE after a frame
// Macro UART_TX_PARITY_EN enables the PARITY state; without it parity_mode
// is ignored and DATA goes straight to STOP.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] clks_per_bit,
  input  logic [1:0]       parity_mode,
  uart_tx_param_if.slave   tx_if,
  output logic             tx_serial,
  output logic             tx_busy,
  output logic             tx_done
);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_cfg
    $error("uart_tx_param: DATA_BITS or STOP_BITS out of range");
  end

  localparam int STOP_N = (STOP_BITS >= STOP_BITS_MAX) ? STOP_BITS_MAX : STOP_BITS_MIN;
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_N - 1);

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   data_q, data_d;     // shifts right, bit 0 is next out
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_CNT_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   serial_q, serial_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   accept, bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_q, par_d;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif

  // ready_q is only ever high in IDLE, so it alone qualifies the accept.
  assign accept = tx_if.tx_valid && ready_q;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .en      (busy_q),
    .period  (div_q),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    serial_d  = serial_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        if (accept) begin
          state_d   = ST_START;
          serial_d  = 1'b0;
          data_d    = tx_if.tx_data;
          div_d     = (clks_per_bit == '0) ? DIV_W'(1) : clks_per_bit;
          bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          par_en_d  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
          par_d     = (^tx_if.tx_data) ^ (parity_mode == PAR_ODD);
`endif
        end
      end
      ST_START: if (bit_end) begin
        state_d  = ST_DATA;
        serial_d = data_q[0];
        data_d   = data_q >> 1;
      end
      ST_DATA: if (bit_end) begin
        if (bit_idx_q == LAST_DATA) begin
          bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          if (par_en_q) begin
            state_d  = ST_PARITY;
            serial_d = par_q;
          end else begin
            state_d  = ST_STOP;
            serial_d = 1'b1;
          end
`else
          state_d  = ST_STOP;
          serial_d = 1'b1;
`endif
        end else begin
          bit_idx_d = bit_idx_q + BIT_CNT_W'(1);
          serial_d  = data_q[0];
          data_d    = data_q >> 1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) begin
        state_d   = ST_STOP;
        serial_d  = 1'b1;
        bit_idx_d = '0;
      end
`endif
      ST_STOP: if (bit_end) begin
        if (bit_idx_q == LAST_STOP) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + BIT_CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b1;
      end
    endcase
    // Status flags track the next state so they are registered, not decoded.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      div_q     <= DIV_W'(1);
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_q     <= par_d;
`endif
    end
  end

  assign tx_if.tx_ready = ready_q;
  assign tx_serial      = serial_q;
  assign tx_busy        = busy_q;
  assign tx_done        = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: dut1 has one stop bit, dut2 two.
// Cycle i after an accept edge is sampled on the i-th following negedge.
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] cpb1, cpb2;
  logic [1:0]  pm1, pm2;
  logic        ser1, busy1, done1, ser2, busy2, done2;

  uart_tx_param_if #(.DATA_BITS(8)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();

  uart_tx_param #(.DATA_BITS(8), .DIV_W(16), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .clks_per_bit(cpb1), .parity_mode(pm1), .tx_if(if1),
    .tx_serial(ser1), .tx_busy(busy1), .tx_done(done1));

  uart_tx_param #(.DATA_BITS(8), .DIV_W(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .clks_per_bit(cpb2), .parity_mode(pm2), .tx_if(if2),
    .tx_serial(ser2), .tx_busy(busy2), .tx_done(done2));

  int checks = 0;
  int errors = 0;
  logic ln [0:127];
  logic dn [0:127];
  logic rd [0:127];
  logic bz [0:127];

  // Accept one frame on dut1 and record n cycles; optionally change the
  // inputs mid-frame (after sampling cycle chg_at) to prove they are latched.
  task send_cap(input logic [7:0] d, input logic [15:0] cpb, input logic [1:0] pm,
                input int n, input int chg_at, input logic [15:0] chg_cpb);
    @(negedge clk);
    if1.tx_data = d; cpb1 = cpb; pm1 = pm; if1.tx_valid = 1'b1;
    @(posedge clk);
    #1 if1.tx_valid = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      ln[i] = ser1; dn[i] = done1; rd[i] = if1.tx_ready; bz[i] = busy1;
      if (i == chg_at) begin cpb1 = chg_cpb; if1.tx_data = ~d; pm1 = ~pm; end
    end
    pm1 = pm;
  endtask

  task test_reset;
    if1.tx_valid = 1'b1; if1.tx_data = 8'h3C; cpb1 = 16'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ser1, if1.tx_ready, busy1, done1} !== 4'b1000) begin
        errors++; $display("FAIL reset_state got ser/rdy/busy/done=%b exp 1000", {ser1, if1.tx_ready, busy1, done1});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if1.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise got %b exp 1", if1.tx_ready); end
    checks++;
    if (busy1 !== 1'b0 || ser1 !== 1'b1) begin
      errors++; $display("FAIL reset_no_accept got busy=%b ser=%b exp 0 1", busy1, ser1);
    end
    if1.tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy1); end
  endtask

  task test_basic;
    logic [9:0] exp_a5;
    exp_a5 = 10'b1101001010;  // line bits 0..9: 0,1,0,1,0,0,1,0,1,1
    send_cap(8'hA5, 16'd4, 2'b00, 44, 0, 16'd0);
    for (int i = 1; i <= 40; i++) begin
      checks++;
      if (ln[i] !== exp_a5[(i-1)/4]) begin
        errors++; $display("FAIL basic_line cyc %0d got %b exp %b", i, ln[i], exp_a5[(i-1)/4]);
      end
    end
    for (int i = 1; i <= 44; i++) begin
      checks++;
      if (dn[i] !== (i == 41)) begin
        errors++; $display("FAIL basic_done cyc %0d got %b exp %b", i, dn[i], (i == 41));
      end
    end
    checks++;
    if (bz[40] !== 1'b1 || bz[41] !== 1'b0 || rd[41] !== 1'b1 || rd[40] !== 1'b0) begin
      errors++; $display("FAIL basic_status got busy40/41=%b%b rdy40/41=%b%b exp 10 01", bz[40], bz[41], rd[40], rd[41]);
    end
    checks++;
    if (ln[41] !== 1'b1 || ln[44] !== 1'b1) begin
      errors++; $display("FAIL basic_idle_line got %b%b exp 11", ln[41], ln[44]);
    end
  endtask

  task test_zero_div;
    send_cap(8'hFF, 16'd0, 2'b00, 14, 0, 16'd0);
    checks++;
    if (ln[1] !== 1'b0) begin errors++; $display("FAIL zdiv_start got %b exp 0", ln[1]); end
    for (int i = 2; i <= 14; i++) begin
      checks++;
      if (ln[i] !== 1'b1) begin errors++; $display("FAIL zdiv_line cyc %0d got %b exp 1", i, ln[i]); end
      checks++;
      if (dn[i] !== (i == 11)) begin errors++; $display("FAIL zdiv_done cyc %0d got %b exp %b", i, dn[i], (i == 11)); end
    end
    checks++;
    if (bz[10] !== 1'b1 || bz[11] !== 1'b0) begin
      errors++; $display("FAIL zdiv_busy got %b%b exp 10", bz[10], bz[11]);
    end
  endtask

  task test_parity;
`ifdef UART_TX_PARITY_EN
    send_cap(8'h07, 16'd4, 2'b01, 48, 0, 16'd0);
    checks++;
    if (ln[33] !== 1'b0) begin errors++; $display("FAIL par_even_d7 got %b exp 0", ln[33]); end
    for (int i = 37; i <= 44; i++) begin
      checks++;
      if (ln[i] !== 1'b1) begin errors++; $display("FAIL par_even_line cyc %0d got %b exp 1", i, ln[i]); end
    end
    for (int i = 1; i <= 48; i++) begin
      checks++;
      if (dn[i] !== (i == 45)) begin errors++; $display("FAIL par_even_done cyc %0d got %b exp %b", i, dn[i], (i == 45)); end
    end
    send_cap(8'h07, 16'd4, 2'b10, 48, 0, 16'd0);
    for (int i = 37; i <= 44; i++) begin
      checks++;
      if (ln[i] !== (i >= 41)) begin errors++; $display("FAIL par_odd_line cyc %0d got %b exp %b", i, ln[i], (i >= 41)); end
    end
    for (int i = 1; i <= 48; i++) begin
      checks++;
      if (dn[i] !== (i == 45)) begin errors++; $display("FAIL par_odd_done cyc %0d got %b exp %b", i, dn[i], (i == 45)); end
    end
`else
    // Parity compiled out: parity_mode must not lengthen the frame.
    send_cap(8'h07, 16'd4, 2'b01, 44, 0, 16'd0);
    for (int i = 37; i <= 40; i++) begin
      checks++;
      if (ln[i] !== 1'b1) begin errors++; $display("FAIL nopar_stop cyc %0d got %b exp 1", i, ln[i]); end
    end
    for (int i = 1; i <= 44; i++) begin
      checks++;
      if (dn[i] !== (i == 41)) begin errors++; $display("FAIL nopar_done cyc %0d got %b exp %b", i, dn[i], (i == 41)); end
    end
`endif
  endtask

  task test_midframe_change;
    send_cap(8'hA5, 16'd4, 2'b00, 44, 2, 16'd8);
    checks++;
    if ({ln[4], ln[5], ln[9], ln[33]} !== 4'b0101) begin
      errors++; $display("FAIL mid_line got %b exp 0101", {ln[4], ln[5], ln[9], ln[33]});
    end
    for (int i = 1; i <= 44; i++) begin
      checks++;
      if (dn[i] !== (i == 41)) begin errors++; $display("FAIL mid_done cyc %0d got %b exp %b", i, dn[i], (i == 41)); end
    end
    send_cap(8'h01, 16'd8, 2'b00, 84, 0, 16'd0);
    checks++;
    if ({ln[8], ln[9], ln[16], ln[17]} !== 4'b0110) begin
      errors++; $display("FAIL next8_line got %b exp 0110", {ln[8], ln[9], ln[16], ln[17]});
    end
    for (int i = 1; i <= 84; i++) begin
      checks++;
      if (dn[i] !== (i == 81)) begin errors++; $display("FAIL next8_done cyc %0d got %b exp %b", i, dn[i], (i == 81)); end
    end
  endtask

  task test_reset_midframe;
    int seen_done;
    @(negedge clk);
    if1.tx_data = 8'h00; cpb1 = 16'd4; if1.tx_valid = 1'b1;
    @(posedge clk);
    #1 if1.tx_valid = 1'b0;
    repeat (13) @(negedge clk);   // first cycle of data bit 2
    checks++;
    if (ser1 !== 1'b0) begin errors++; $display("FAIL rstmid_pre got %b exp 0", ser1); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ser1, busy1, if1.tx_ready, done1} !== 4'b1000) begin
      errors++; $display("FAIL rstmid_abort got ser/busy/rdy/done=%b exp 1000", {ser1, busy1, if1.tx_ready, done1});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if1.tx_ready !== 1'b1 || done1 !== 1'b0) begin
      errors++; $display("FAIL rstmid_release got rdy=%b done=%b exp 1 0", if1.tx_ready, done1);
    end
    seen_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done1 !== 1'b0 || busy1 !== 1'b0 || ser1 !== 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin errors++; $display("FAIL rstmid_quiet got %0d bad cycles exp 0", seen_done); end
  endtask

  task test_back_to_back;
    int ndone;
    @(negedge clk);
    if2.tx_data = 8'h55; cpb2 = 16'd4; pm2 = 2'b00; if2.tx_valid = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 95; i++) begin
      @(negedge clk);
      ln[i] = ser2; dn[i] = done2; rd[i] = if2.tx_ready; bz[i] = busy2;
      if (i == 1)  if2.tx_data = 8'hAA;
      if (i == 46) if2.tx_valid = 1'b0;
    end
    checks++;
    if ({ln[5], ln[9]} !== 2'b10) begin errors++; $display("FAIL b2b_f1_data got %b exp 10", {ln[5], ln[9]}); end
    for (int i = 37; i <= 45; i++) begin
      checks++;
      if (ln[i] !== 1'b1) begin errors++; $display("FAIL b2b_stop cyc %0d got %b exp 1", i, ln[i]); end
    end
    checks++;
    if (ln[46] !== 1'b0 || rd[45] !== 1'b1 || bz[46] !== 1'b1) begin
      errors++; $display("FAIL b2b_gap got ln46=%b rdy45=%b busy46=%b exp 0 1 1", ln[46], rd[45], bz[46]);
    end
    checks++;
    if ({ln[50], ln[54]} !== 2'b01) begin errors++; $display("FAIL b2b_f2_data got %b exp 01", {ln[50], ln[54]}); end
    for (int i = 82; i <= 95; i++) begin
      checks++;
      if (ln[i] !== 1'b1) begin errors++; $display("FAIL b2b_f2_stop cyc %0d got %b exp 1", i, ln[i]); end
    end
    ndone = 0;
    for (int i = 1; i <= 95; i++) if (dn[i] === 1'b1) ndone++;
    checks++;
    if (ndone != 2 || dn[45] !== 1'b1 || dn[90] !== 1'b1) begin
      errors++; $display("FAIL b2b_done got count=%0d d45=%b d90=%b exp 2 1 1", ndone, dn[45], dn[90]);
    end
  endtask

  initial begin
    if1.tx_valid = 1'b0; if1.tx_data = '0; cpb1 = 16'd4; pm1 = 2'b00;
    if2.tx_valid = 1'b0; if2.tx_data = '0; cpb2 = 16'd4; pm2 = 2'b00;
    test_reset;
    test_basic;
    test_zero_div;
    test_parity;
    test_midframe_change;
    test_reset_midframe;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the payload bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter DIV_W, default 16, giving the width of the runtime bit-period divisor.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, giving the stop-bit count (legal 1 or 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port clks_per_bit, input, DIV_W bits: clock cycles per serial bit.
REQ-007 The block SHALL have port parity_mode, input, 2 bits: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 The block SHALL have port tx_valid, input, 1 bit: the byte on tx_data is offered.
REQ-009 The block SHALL have port tx_data, input, DATA_BITS bits: payload, transmitted LSB first.
REQ-010 The block SHALL have port tx_ready, output, 1 bit: high only in IDLE; a transfer occurs on any edge where tx_valid and tx_ready are both high.
REQ-011 The block SHALL have port tx_serial, output, 1 bit: the serial line, idle high.
REQ-012 The block SHALL have port tx_busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port tx_done, output, 1 bit: a one-cycle pulse on frame completion.

Function
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; there is no separate cleanup state.
REQ-015 On accept, the block SHALL latch tx_data, clks_per_bit and parity_mode; input changes mid-frame SHALL NOT affect the frame in flight.
REQ-016 A latched clks_per_bit of 0 SHALL be treated as 1; each bit SHALL last exactly max(clks_per_bit,1) cycles.
REQ-017 Latency: after an accept at edge N, tx_serial SHALL be 0 (start bit) from edge N+1.
REQ-018 Transitions SHALL be IDLE->START on accept, START->DATA, DATA->DATA until bit index DATA_BITS-1, then DATA->PARITY if parity is enabled, else DATA->STOP, PARITY->STOP, and STOP->IDLE after STOP_BITS bit periods.
REQ-019 The parity bit SHALL be the XOR of the payload for even parity and its inverse for odd parity.
REQ-020 tx_done SHALL be high for exactly the one cycle following the last stop-bit cycle, coincident with the return to IDLE and tx_ready=1.
REQ-021 For back-to-back frames, an accept in the tx_done cycle SHALL give exactly one idle-high cycle between the stop bit and the next start bit.
REQ-022 tx_valid outside IDLE SHALL be ignored, with no buffering.
REQ-023 The bit counter and divisor counter SHALL be sized so that no wrap-around occurs for any legal parameter value.

Reset
REQ-024 While rst=1, the block SHALL drive state IDLE, tx_serial=1, tx_ready=0, tx_busy=0, tx_done=0 and clear all counters and latches; tx_ready SHALL rise on the first edge after rst falls.
REQ-025 If rst asserts mid-frame, the frame SHALL be abandoned, tx_serial SHALL go high at the next edge, and no tx_done pulse SHALL be produced.
REQ-026 rst SHALL take priority over a simultaneous tx_valid.

Configuration
REQ-027 Parity support SHALL be controlled by macro UART_TX_PARITY_EN. When defined, the PARITY state and parity_mode decode SHALL be present. When undefined, parity_mode SHALL be ignored, the PARITY state SHALL be absent, and DATA SHALL transition directly to STOP.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum, the parity_mode encodings and the legal-range constants for DATA_BITS and STOP_BITS.
REQ-029 The bit-period counter SHALL be a sub-module uart_baud_gen, which emits a one-cycle bit_end strobe and is restarted on accept.

Verification
REQ-030 With DATA_BITS=8, clks_per_bit=4 and no parity, sending 0xA5 SHALL produce the line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, with tx_done at cycle 41 after accept.
REQ-031 With macro defined and even parity, sending 0x07 SHALL give parity bit 1; with odd parity, sending 0x07 SHALL give parity bit 0, and each frame SHALL be 11 bit periods long.
REQ-032 With STOP_BITS=2 and tx_valid held high with 0x55 then 0xAA, the bench SHALL see two stop periods, exactly 1 idle cycle between frames and 2 tx_done pulses.
REQ-033 With clks_per_bit=0, sending 0xFF SHALL produce 1-cycle bits and a 10-cycle frame.
REQ-034 With rst asserted at the 3rd data bit, tx_serial SHALL be 1 on the next edge, with no tx_done, and tx_ready=1 on the first edge after release.
REQ-035 With clks_per_bit changed from 4 to 8 mid-frame, the current frame SHALL keep 4-cycle bits and the next frame SHALL use 8-cycle bits.
